// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave with oversampled pins, tx holding buffer and rx valid/ack.
// Define SPI_SLAVE_OVERRUN_EN to add the sticky rx_overrun output.
module spi_slave #(
  parameter int                DATA_W       = 8,
  parameter int                SYNC_STAGES  = 2,
  parameter logic [DATA_W-1:0] IDLE_PATTERN = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ack,
  output logic              busy,
  output logic              frame_err
`ifdef SPI_SLAVE_OVERRUN_EN
  ,
  output logic              rx_overrun
`endif
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state;

  logic [SYNC_STAGES-1:0] sck_sr, cs_sr, mosi_sr, settle;
  logic                   sck_sync, cs_sync;
  logic                   sck_prev, cs_prev, armed;
  logic                   sck_rise, sck_fall, cs_fall, cs_rise, mosi_s;
  logic [DATA_W-1:0]      shift_tx, shift_rx, tx_buf;
  logic [DATA_W-1:0]      rx_word, next_tx;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   tx_pend, word_edge, last_bit;

  assign sck_sync = sck_sr[SYNC_STAGES-1];
  assign cs_sync  = cs_sr[SYNC_STAGES-1];
  assign rx_word  = {shift_rx[DATA_W-2:0], mosi_s};
  assign next_tx  = tx_pend ? tx_buf : IDLE_PATTERN;
  assign last_bit = (bit_cnt == CNT_W'(DATA_W-1));
  assign tx_ready = ~tx_pend;

  // Edge pulses are registered together with mosi so the FSM sees them aligned.
  // armed requires a genuinely observed cs_n high after reset before any cs_fall counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sr   <= '0;
      cs_sr    <= '1;
      mosi_sr  <= '0;
      settle   <= '0;
      sck_prev <= 1'b0;
      cs_prev  <= 1'b1;
      armed    <= 1'b0;
      sck_rise <= 1'b0;
      sck_fall <= 1'b0;
      cs_fall  <= 1'b0;
      cs_rise  <= 1'b0;
      mosi_s   <= 1'b0;
    end else begin
      sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
      cs_sr    <= {cs_sr[SYNC_STAGES-2:0], cs_n};
      mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], mosi};
      settle   <= {settle[SYNC_STAGES-2:0], 1'b1};
      sck_prev <= sck_sync;
      cs_prev  <= cs_sync;
      armed    <= armed | (settle[SYNC_STAGES-1] & cs_sync);
      sck_rise <= sck_sync & ~sck_prev;
      sck_fall <= ~sck_sync & sck_prev;
      cs_fall  <= armed & cs_prev & ~cs_sync;
      cs_rise  <= cs_sync & ~cs_prev;
      mosi_s   <= mosi_sr[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      shift_tx  <= '0;
      shift_rx  <= '0;
      tx_buf    <= '0;
      tx_pend   <= 1'b0;
      bit_cnt   <= '0;
      word_edge <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
      rx_overrun <= 1'b0;
`endif
    end else begin
      frame_err <= 1'b0;
      if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
        rx_overrun <= 1'b0;
`endif
      end
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state     <= SHIFT;
            shift_tx  <= next_tx;
            tx_pend   <= 1'b0;
            bit_cnt   <= '0;
            miso      <= next_tx[DATA_W-1];
            miso_oe   <= 1'b1;
            busy      <= 1'b1;
            word_edge <= 1'b0;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state     <= IDLE;
            miso      <= 1'b0;
            miso_oe   <= 1'b0;
            busy      <= 1'b0;
            frame_err <= (bit_cnt != '0);
            bit_cnt   <= '0;
            word_edge <= 1'b0;
          end else if (sck_rise) begin
            shift_rx <= rx_word;
            if (last_bit) begin
              bit_cnt   <= '0;
              rx_data   <= rx_word;
              rx_valid  <= 1'b1;
              shift_tx  <= next_tx;
              tx_pend   <= 1'b0;
              word_edge <= 1'b1;
`ifdef SPI_SLAVE_OVERRUN_EN
              if (rx_valid && !rx_ack) rx_overrun <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (sck_fall) begin
            // The first fall of a new word shows the reloaded MSB as-is.
            if (word_edge) begin
              miso      <= shift_tx[DATA_W-1];
              word_edge <= 1'b0;
            end else begin
              shift_tx <= shift_tx << 1;
              miso     <= shift_tx[DATA_W-2];
            end
          end
        end
        default: state <= IDLE;
      endcase
      // A load in the same cycle as a consume lands after it.
      if (tx_load && tx_ready) begin
        tx_buf  <= tx_data;
        tx_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - scoreboard bench for spi_slave.
`timescale 1ns/1ps
module tb_spi_slave;
  logic       clk = 0, rst_n = 0, sck = 0, cs_n = 1, mosi = 0;
  logic       tx_load = 0, rx_ack = 0;
  logic [7:0] tx_data = 0;
  logic       miso, miso_oe, tx_ready, rx_valid, busy, frame_err;
  logic [7:0] rx_data;
`ifdef SPI_SLAVE_OVERRUN_EN
  logic       rx_overrun;
`endif

  int total = 0, bad = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_miso[$];
  bit mon_en = 1, ack_req = 0;
  int fe_cnt = 0, fe_run = 0, fe_max = 0;
  logic [7:0] mbyte = 0;
  int mbits = 0;

  spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_PATTERN(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .frame_err(frame_err)
`ifdef SPI_SLAVE_OVERRUN_EN
    , .rx_overrun(rx_overrun)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // rx monitor: compares each presented word against the scoreboard and acks it.
  initial forever begin
    @(negedge clk);
    if (frame_err) fe_run++; else fe_run = 0;
    if (fe_run == 1) fe_cnt++;
    if (fe_run > fe_max) fe_max = fe_run;
    if (rx_ack) rx_ack = 0;
    else if (ack_req) begin
      rx_ack = 1;
      ack_req = 0;
    end else if (mon_en && rx_valid) begin
      if (exp_rx.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got %0h expected no word", rx_data);
      end else begin
        check("rx_data", rx_data, exp_rx.pop_front());
      end
      rx_ack = 1;
    end
  end

  // miso monitor: collects bits at each sck rise like the master would.
  always @(posedge sck or posedge cs_n or negedge rst_n) begin
    if (!rst_n || cs_n) mbits = 0;
    else begin
      mbyte = {mbyte[6:0], miso};
      mbits++;
      if (mbits == 8) begin
        mbits = 0;
        if (exp_miso.size() == 0) begin
          total++;
          bad++;
          $display("FAIL miso_unexpected: got %0h expected no word", mbyte);
        end else begin
          check("miso_byte", mbyte, exp_miso.pop_front());
        end
      end
    end
  end

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #50 sck = 1;
      #50 sck = 0;
    end
  endtask

  task automatic cs_lo();
    cs_n = 0;
    #100;
  endtask

  task automatic cs_hi();
    #100 cs_n = 1;
    #200;
  endtask

  task automatic load(input logic [7:0] d);
    tx_data = d;
    tx_load = 1;
    #10 tx_load = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #10;
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_rx_data", rx_data, 0);
    #10 rst_n = 1;
    #100;

    // single word; second load while full must be ignored
    load(8'hA5);
    check("t1_tx_ready_full", tx_ready, 0);
    load(8'h5A);
    exp_miso.push_back(8'hA5);
    exp_rx.push_back(8'h3C);
    cs_lo();
    check("t1_busy", busy, 1);
    check("t1_miso_oe", miso_oe, 1);
    check("t1_tx_ready_after_csfall", tx_ready, 1);
    spi_bits(8'h3C, 8);
    cs_hi();
    check("t1_busy_end", busy, 0);
    check("t1_frame_err_cnt", fe_cnt, 0);

    // back-to-back words, second tx loaded mid-word
    load(8'h11);
    exp_miso.push_back(8'h11);
    exp_miso.push_back(8'h22);
    exp_rx.push_back(8'hF0);
    exp_rx.push_back(8'h0F);
    cs_lo();
    fork
      begin
        spi_bits(8'hF0, 8);
        spi_bits(8'h0F, 8);
      end
      begin
        #300 load(8'h22);
      end
    join
    cs_hi();
    check("t2_tx_ready", tx_ready, 1);

    // empty tx buffer
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h55);
    cs_lo();
    spi_bits(8'h55, 8);
    cs_hi();

    // abort after 3 bits, then a clean frame
    cs_lo();
    spi_bits(8'hC3, 3);
    cs_hi();
    check("t4_frame_err_cnt", fe_cnt, 1);
    check("t4_rx_valid", rx_valid, 0);
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h81);
    cs_lo();
    spi_bits(8'h81, 8);
    cs_hi();

    // overrun: two words without ack
    mon_en = 0;
    exp_miso.push_back(8'hFF);
    exp_miso.push_back(8'hFF);
    cs_lo();
    spi_bits(8'hAA, 8);
    spi_bits(8'hBB, 8);
    cs_hi();
    check("t5_rx_valid", rx_valid, 1);
    check("t5_rx_data", rx_data, 8'hBB);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t5_overrun_set", rx_overrun, 1);
`endif
    ack_req = 1;
    #40;
    check("t5_rx_valid_acked", rx_valid, 0);
`ifdef SPI_SLAVE_OVERRUN_EN
    check("t5_overrun_clr", rx_overrun, 0);
`endif
    mon_en = 1;

    // reset mid-word with cs_n held low
    cs_lo();
    fork
      spi_bits(8'h99, 4);
      begin
        #100 load(8'h77);
      end
    join
    check("t6_tx_ready_pre", tx_ready, 0);
    rst_n = 0;
    #10;
    check("t6_miso", miso, 0);
    check("t6_miso_oe", miso_oe, 0);
    check("t6_rx_data", rx_data, 0);
    check("t6_rx_valid", rx_valid, 0);
    check("t6_tx_ready", tx_ready, 1);
    check("t6_busy", busy, 0);
    check("t6_frame_err", frame_err, 0);
    #20 rst_n = 1;
    #100;
    exp_miso.push_back(8'h00);
    spi_bits(8'h12, 8);
    #100;
    check("t6_busy_ignored", busy, 0);
    check("t6_rx_valid_ignored", rx_valid, 0);
    cs_n = 1;
    #200;
    exp_miso.push_back(8'hFF);
    exp_rx.push_back(8'h5A);
    cs_lo();
    spi_bits(8'h5A, 8);
    cs_hi();

    for (int i = 0; i < 100 && (exp_rx.size() != 0 || exp_miso.size() != 0); i++) #10;
    check("drain_rx", exp_rx.size(), 0);
    check("drain_miso", exp_miso.size(), 0);
    check("frame_err_total", fe_cnt, 1);
    check("frame_err_width", fe_max, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
